// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / flow controller for the 5-stage RISC-V core.
//
// Produces the per-stage load, hold and clear strobes for the pipeline
// registers. Three hazards are resolved, in this priority order:
//   1. data-memory wait   -> freeze ID/EX, EX/MEM and MEM/WB, hold PC and IF/ID
//   2. control flush      -> clear IF/ID and ID/EX, let the PC load the target
//   3. load-use hazard    -> hold PC and IF/ID, insert one bubble into ID/EX
//
// The strobes are combinational from the current inputs and the registered
// state, so they act in the same cycle that the hazard is seen.
//
// Handshake: dmem_req/dmem_ready form a valid/ready pair. An access completes
// in a cycle where both are high; a cycle with dmem_req high and dmem_ready
// low is a memory wait and freezes the back end of the pipeline.
//
// A taken branch seen during a freeze cannot be applied, because IF/ID and
// ID/EX must stay intact. It is remembered in flush_pending and applied in
// the first cycle after the freeze ends.
//
// Optional feature macro: HAZARD_PERF_EN
//   defined   -> stall_cnt / flush_cnt / freeze_cnt count active cycles of
//                the load-use, flush and freeze rules (wrap modulo 2^CNT_W)
//   undefined -> the counter ports are tied to zero and no flops are built
//
// state_dbg exposes the wait FSM (0 = RUN, 1 = MEM_WAIT) for observation.

module hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             Rs1_used_ID,
    input  logic             Rs2_used_ID,
    input  logic [4:0]       wrin_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IFID_CLEAR,
    output logic             IDEX_CLEAR,
    output logic             FREEZE,
    output logic             TIMEOUT_ERR,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic             state_dbg
);

    localparam int WCNT_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_TIMEOUT);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic              flush_pending;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_nxt;

    logic mem_stall;
    logic load_use;
    logic flush;
    logic rule_freeze;
    logic rule_flush;
    logic rule_stall;

    // Hazard conditions for the current cycle.
    always_comb begin
        mem_stall = dmem_req & ~dmem_ready;
        load_use  = MemRead_EX & (wrin_EX != 5'd0) &
                    ((Rs1_used_ID & (wrin_EX == Rs1_ID)) |
                     (Rs2_used_ID & (wrin_EX == Rs2_ID)));
        flush     = branch_taken_EX | flush_pending;
        // Exactly one rule (or none) is active; the freeze dominates so that
        // a flush or bubble never disturbs registers that must hold.
        rule_freeze = mem_stall;
        rule_flush  = ~mem_stall & flush;
        rule_stall  = ~mem_stall & ~flush & load_use;
    end

    // Saturating next value of the consecutive-wait counter.
    always_comb begin
        wait_nxt = wait_cnt;
        if (wait_cnt != WAIT_MAX) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    // Pipeline strobes; reset forces both clears so no stale instruction survives.
    always_comb begin
        PC_WRITE   = 1'b1;
        IFID_WRITE = 1'b1;
        IFID_CLEAR = 1'b0;
        IDEX_CLEAR = 1'b0;
        FREEZE     = 1'b0;
        if (!RESET_N) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            IFID_CLEAR = 1'b1;
            IDEX_CLEAR = 1'b1;
        end else if (rule_freeze) begin
            FREEZE     = 1'b1;
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
        end else if (rule_flush) begin
            // The instruction in ID is discarded, so any load-use on it is moot.
            IFID_CLEAR = 1'b1;
            IDEX_CLEAR = 1'b1;
        end else if (rule_stall) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            IDEX_CLEAR = 1'b1;
        end
    end

    // Wait FSM, deferred flush, wait counter and sticky timeout flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ST_RUN;
            flush_pending <= 1'b0;
            wait_cnt      <= '0;
            TIMEOUT_ERR   <= 1'b0;
        end else begin
            case (state)
                ST_RUN:      if (mem_stall)  state <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (!mem_stall) state <= ST_RUN;
                default:                     state <= ST_RUN;
            endcase

            if (mem_stall) begin
                // Remember a branch that resolves while the pipeline is frozen.
                flush_pending <= flush_pending | branch_taken_EX;
                wait_cnt      <= wait_nxt;
                if (wait_nxt == WAIT_MAX) begin
                    TIMEOUT_ERR <= 1'b1;
                end
            end else begin
                // The release cycle applies any pending flush through rule 2.
                flush_pending <= 1'b0;
                wait_cnt      <= '0;
            end
        end
    end

    assign state_dbg = state;

`ifdef HAZARD_PERF_EN
    // Performance counters: one count per cycle in which each rule is active.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (rule_stall)  stall_cnt  <= stall_cnt + 1'b1;
            if (rule_flush)  flush_cnt  <= flush_cnt + 1'b1;
            if (rule_freeze) freeze_cnt <= freeze_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by randomized cycles,
// every cycle compared against a rule-level reference model.

module tb_hazard_ctrl;

    localparam int WT    = 4;
    localparam int CNT_W = 32;

    // clock / reset
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [4:0]       Rs1_ID = '0, Rs2_ID = '0, wrin_EX = '0;
    logic             Rs1_used_ID = 0, Rs2_used_ID = 0, MemRead_EX = 0;
    logic             branch_taken_EX = 0, dmem_req = 0, dmem_ready = 0;
    logic             PC_WRITE, IFID_WRITE, IFID_CLEAR, IDEX_CLEAR, FREEZE;
    logic             TIMEOUT_ERR, state_dbg;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

    hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
        .Rs1_used_ID(Rs1_used_ID), .Rs2_used_ID(Rs2_used_ID),
        .wrin_EX(wrin_EX), .MemRead_EX(MemRead_EX),
        .branch_taken_EX(branch_taken_EX),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE),
        .IFID_CLEAR(IFID_CLEAR), .IDEX_CLEAR(IDEX_CLEAR),
        .FREEZE(FREEZE), .TIMEOUT_ERR(TIMEOUT_ERR),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
        .state_dbg(state_dbg)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          m_pending;    // a branch was seen during the current freeze
    int          m_waited;     // consecutive freeze cycles so far
    bit          m_err;
    bit          m_in_wait;    // previous cycle was a freeze
    int unsigned m_stalls, m_flushes, m_freezes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_waited = 0; m_err = 0; m_in_wait = 0;
        m_stalls = 0; m_flushes = 0; m_freezes = 0;
    endtask

    function automatic logic [31:0] perf(input int unsigned v);
`ifdef HAZARD_PERF_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic check_counters(input string tag);
        check({tag, ".stall_cnt"},  stall_cnt,  perf(m_stalls));
        check({tag, ".flush_cnt"},  flush_cnt,  perf(m_flushes));
        check({tag, ".freeze_cnt"}, freeze_cnt, perf(m_freezes));
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc(input string tag);
        bit wait_now, hit, fl, lu;
        bit e_pc, e_ifw, e_ifc, e_idc, e_frz;
        @(negedge CLK);
        wait_now = dmem_req && !dmem_ready;
        hit = (wrin_EX != 0) &&
              ((Rs1_used_ID && wrin_EX == Rs1_ID) || (Rs2_used_ID && wrin_EX == Rs2_ID));
        lu = MemRead_EX && hit;
        fl = branch_taken_EX || m_pending;
        if (wait_now)  {e_pc, e_ifw, e_ifc, e_idc, e_frz} = 5'b00001;
        else if (fl)   {e_pc, e_ifw, e_ifc, e_idc, e_frz} = 5'b11110;
        else if (lu)   {e_pc, e_ifw, e_ifc, e_idc, e_frz} = 5'b00010;
        else           {e_pc, e_ifw, e_ifc, e_idc, e_frz} = 5'b11000;
        check({tag, ".PC_WRITE"},    PC_WRITE,    e_pc);
        check({tag, ".IFID_WRITE"},  IFID_WRITE,  e_ifw);
        check({tag, ".IFID_CLEAR"},  IFID_CLEAR,  e_ifc);
        check({tag, ".IDEX_CLEAR"},  IDEX_CLEAR,  e_idc);
        check({tag, ".FREEZE"},      FREEZE,      e_frz);
        check({tag, ".TIMEOUT_ERR"}, TIMEOUT_ERR, m_err);
        check({tag, ".state"},       state_dbg,   m_in_wait);
        check_counters(tag);
        @(posedge CLK);
        if (wait_now) begin
            m_freezes++;
            m_pending = m_pending || branch_taken_EX;
            if (m_waited < WT) m_waited++;
            if (m_waited == WT) m_err = 1;
        end else begin
            if (fl) m_flushes++;
            else if (lu) m_stalls++;
            m_pending = 0;
            m_waited  = 0;
        end
        m_in_wait = wait_now;
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must react at once.
    task automatic do_reset(input string tag);
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst.PC_WRITE"},    PC_WRITE,    1'b0);
        check({tag, ".rst.IFID_WRITE"},  IFID_WRITE,  1'b0);
        check({tag, ".rst.IFID_CLEAR"},  IFID_CLEAR,  1'b1);
        check({tag, ".rst.IDEX_CLEAR"},  IDEX_CLEAR,  1'b1);
        check({tag, ".rst.FREEZE"},      FREEZE,      1'b0);
        check({tag, ".rst.TIMEOUT_ERR"}, TIMEOUT_ERR, 1'b0);
        check({tag, ".rst.state"},       state_dbg,   1'b0);
        check_counters({tag, ".rst"});
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic idle_inputs();
        Rs1_ID = 0; Rs2_ID = 0; Rs1_used_ID = 0; Rs2_used_ID = 0;
        wrin_EX = 0; MemRead_EX = 0; branch_taken_EX = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        do_reset("init");
        cyc("idle");

        // load-use on rs1, then the load leaves EX
        MemRead_EX = 1; wrin_EX = 5; Rs1_ID = 5; Rs1_used_ID = 1;
        cyc("lu_rs1");
        check("lu_rs1.bubble", {PC_WRITE, IDEX_CLEAR}, 2'b01);
        MemRead_EX = 0;
        cyc("lu_after");

        // x0 destination never stalls
        MemRead_EX = 1; wrin_EX = 0; Rs1_ID = 0; Rs1_used_ID = 1;
        cyc("x0");
        // matching but unused operand never stalls
        wrin_EX = 7; Rs1_ID = 3; Rs2_ID = 7; Rs1_used_ID = 0; Rs2_used_ID = 0;
        cyc("unused_rs2");
        Rs2_used_ID = 1;
        cyc("lu_rs2");

        // branch and load-use together: the flush wins
        branch_taken_EX = 1;
        cyc("br_lu");
        idle_inputs();

        // three wait cycles with a branch in the second; flush applied once after
        dmem_req = 1; dmem_ready = 0;
        cyc("frz1");
        branch_taken_EX = 1;
        cyc("frz2");
        branch_taken_EX = 0;
        cyc("frz3");
        dmem_ready = 1;
        cyc("release_flush");
        check("release_flush.clears", {IFID_CLEAR, IDEX_CLEAR}, 2'b00);
        dmem_req = 0;
        cyc("after_release");

        // timeout: six wait cycles, flag rises at the fourth edge and sticks
        do_reset("to");
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 6; i++) cyc($sformatf("to_wait%0d", i));
        check("to.err_set", TIMEOUT_ERR, 1'b1);
        dmem_ready = 1;
        cyc("to_rel");
        idle_inputs();
        cyc("to_idle");
        check("to.err_sticky", TIMEOUT_ERR, 1'b1);

        // reset in the middle of a freeze with a pending branch: the flush is lost
        dmem_req = 1; branch_taken_EX = 1;
        cyc("mid_frz");
        do_reset("mid");
        idle_inputs();
        cyc("mid_after");

        // performance counters: 2 load-use, 3 flush, 5 freeze cycles
        do_reset("perf");
        MemRead_EX = 1; wrin_EX = 9; Rs2_ID = 9; Rs2_used_ID = 1;
        for (int i = 0; i < 2; i++) cyc("perf_lu");
        idle_inputs();
        branch_taken_EX = 1;
        for (int i = 0; i < 3; i++) cyc("perf_fl");
        idle_inputs();
        dmem_req = 1;
        for (int i = 0; i < 5; i++) cyc("perf_fz");
        idle_inputs();
        cyc("perf_end");
`ifdef HAZARD_PERF_EN
        check("perf.stall",  stall_cnt,  32'd2);
        check("perf.flush",  flush_cnt,  32'd3);
        check("perf.freeze", freeze_cnt, 32'd5);
`else
        check("perf.stall",  stall_cnt,  32'd0);
        check("perf.flush",  flush_cnt,  32'd0);
        check("perf.freeze", freeze_cnt, 32'd0);
`endif

        // randomized cycles with occasional reset
        do_reset("rnd");
        for (int i = 0; i < 600; i++) begin
            Rs1_ID          = 5'($urandom_range(0, 3));
            Rs2_ID          = 5'($urandom_range(0, 3));
            wrin_EX         = 5'($urandom_range(0, 3));
            Rs1_used_ID     = 1'($urandom_range(0, 1));
            Rs2_used_ID     = 1'($urandom_range(0, 1));
            MemRead_EX      = 1'($urandom_range(0, 1));
            branch_taken_EX = ($urandom_range(0, 5) == 0);
            dmem_req        = 1'($urandom_range(0, 1));
            dmem_ready      = ($urandom_range(0, 2) == 0);
            cyc("rnd");
            if ($urandom_range(0, 99) == 0) do_reset("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
